// File: rtl/iob_fifo_sync_asym_if.sv
// Handshake bundle for iob_fifo_sync_asym: write/read requests, data,
// full/empty flags and occupancy level. slave = FIFO side, master = user side.
interface iob_fifo_sync_asym_if #(
  parameter int W_DATA_W = 8,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W   = 4
) ();
  logic                w_en_i;
  logic [W_DATA_W-1:0] w_data_i;
  logic                w_full_o;
  logic                r_en_i;
  logic [R_DATA_W-1:0] r_data_o;
  logic                r_empty_o;
  logic [ADDR_W:0]     level_o;

  modport slave (
    input  w_en_i,
    input  w_data_i,
    output w_full_o,
    input  r_en_i,
    output r_data_o,
    output r_empty_o,
    output level_o
  );

  modport master (
    output w_en_i,
    output w_data_i,
    input  w_full_o,
    output r_en_i,
    input  r_data_o,
    input  r_empty_o,
    input  level_o
  );
endinterface

// File: rtl/iob_fifo_sync_asym.sv
// Single-clock FIFO with independent write/read widths over R external RAM banks.
// Ports: clk_i, rst_i (sync, active high), cke_i, fifo_if (slave handshake:
// w_en/w_data/w_full, r_en/r_data/r_empty, level), ext_mem_* bank interface.
// Optional macro IOB_FIFO_SYNC_ASYM_ERR_EN adds sticky w_overflow_o/r_underflow_o.
module iob_fifo_sync_asym #(
  parameter  int W_DATA_W  = 8,
  parameter  int R_DATA_W  = 8,
  parameter  int ADDR_W    = 4,
  localparam int MAXDATA_W = (W_DATA_W > R_DATA_W) ? W_DATA_W : R_DATA_W,
  localparam int MINDATA_W = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W,
  localparam int R         = MAXDATA_W / MINDATA_W,
  localparam int MINADDR_W = ADDR_W - $clog2(R)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cke_i,
`ifdef IOB_FIFO_SYNC_ASYM_ERR_EN
  output logic                 w_overflow_o,
  output logic                 r_underflow_o,
`endif
  iob_fifo_sync_asym_if.slave  fifo_if,
  output logic                 ext_mem_clk_o,
  output logic [R-1:0]         ext_mem_w_en_o,
  output logic [MINADDR_W-1:0] ext_mem_w_addr_o,
  output logic [MAXDATA_W-1:0] ext_mem_w_data_o,
  output logic [R-1:0]         ext_mem_r_en_o,
  output logic [MINADDR_W-1:0] ext_mem_r_addr_o,
  input  logic [MAXDATA_W-1:0] ext_mem_r_data_i
);

  localparam int SEL_W    = $clog2(R);
  localparam int W_ADDR_W =
    (W_DATA_W == MAXDATA_W) ? MINADDR_W : ADDR_W;
  localparam int R_ADDR_W =
    (R_DATA_W == MAXDATA_W) ? MINADDR_W : ADDR_W;
  localparam int W_INC    = W_DATA_W / MINDATA_W;
  localparam int R_DEC    = R_DATA_W / MINDATA_W;

  localparam logic [ADDR_W:0] W_INC_L = (ADDR_W+1)'(W_INC);
  localparam logic [ADDR_W:0] R_DEC_L = (ADDR_W+1)'(R_DEC);
  localparam logic [ADDR_W:0] FULL_TH =
    (ADDR_W+1)'((2**ADDR_W) - W_INC);
  localparam logic [W_ADDR_W:0] W_ONE = (W_ADDR_W+1)'(1);
  localparam logic [R_ADDR_W:0] R_ONE = (R_ADDR_W+1)'(1);

  logic [W_ADDR_W:0] wptr_q, wptr_d;
  logic [R_ADDR_W:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              w_full_q;
  logic              r_empty_q;
  logic              r_vld_q;
  logic              w_acc;
  logic              r_acc;
  logic [R_DATA_W-1:0] r_word;

  assign ext_mem_clk_o = clk_i;

  assign w_acc = cke_i & fifo_if.w_en_i & ~w_full_q;
  assign r_acc = cke_i & fifo_if.r_en_i & ~r_empty_q;

  // Level counts narrow units so both widths share one occupancy measure.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (w_acc) begin
      wptr_d  = wptr_q + W_ONE;
      level_d = level_d + W_INC_L;
    end
    if (r_acc) begin
      rptr_d  = rptr_q + R_ONE;
      level_d = level_d - R_DEC_L;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      w_full_q  <= 1'b0;
      r_empty_q <= 1'b1;
      r_vld_q   <= 1'b0;
    end else if (cke_i) begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      w_full_q  <= level_d > FULL_TH;
      r_empty_q <= level_d < R_DEC_L;
      if (r_acc) r_vld_q <= 1'b1;
    end
  end

  // Pointer MSBs only carry wrap parity; occupancy comes from level.
  logic unused_ptr_msb;
  assign unused_ptr_msb = wptr_q[W_ADDR_W] ^ rptr_q[R_ADDR_W];

  // Write side
  if (W_DATA_W >= R_DATA_W) begin : g_w_wide
    assign ext_mem_w_en_o   = {R{w_acc}};
    assign ext_mem_w_addr_o = wptr_q[MINADDR_W-1:0];
    assign ext_mem_w_data_o = fifo_if.w_data_i;
  end else begin : g_w_narrow
    logic [SEL_W-1:0] w_sel;
    assign w_sel = wptr_q[SEL_W-1:0];
    assign ext_mem_w_en_o =
      {{(R-1){1'b0}}, w_acc} << w_sel;
    assign ext_mem_w_addr_o = wptr_q[ADDR_W-1:SEL_W];
    // Replicate so whichever bank is enabled sees the byte.
    assign ext_mem_w_data_o = {R{fifo_if.w_data_i}};
  end

  // Read side
  if (R_DATA_W >= W_DATA_W) begin : g_r_wide
    assign ext_mem_r_en_o   = {R{r_acc}};
    assign ext_mem_r_addr_o = rptr_q[MINADDR_W-1:0];
    assign r_word           = ext_mem_r_data_i;
  end else begin : g_r_narrow
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] sel_q;
    assign r_sel = rptr_q[SEL_W-1:0];
    assign ext_mem_r_en_o =
      {{(R-1){1'b0}}, r_acc} << r_sel;
    assign ext_mem_r_addr_o = rptr_q[ADDR_W-1:SEL_W];

    // Bank select follows the RAM's registered read by one edge.
    always_ff @(posedge clk_i) begin
      if (rst_i) sel_q <= '0;
      else if (r_acc) sel_q <= r_sel;
    end

    always_comb begin
      r_word = '0;
      for (int p = 0; p < R; p++) begin
        if (sel_q == SEL_W'(p))
          r_word = ext_mem_r_data_i[p*MINDATA_W +: MINDATA_W];
      end
    end
  end

  // RAM output register is not reset; mask it until a read lands.
  assign fifo_if.r_data_o  = r_vld_q ? r_word : '0;
  assign fifo_if.w_full_o  = w_full_q;
  assign fifo_if.r_empty_o = r_empty_q;
  assign fifo_if.level_o   = level_q;

`ifdef IOB_FIFO_SYNC_ASYM_ERR_EN
  logic w_ovf_q;
  logic r_unf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_ovf_q <= 1'b0;
      r_unf_q <= 1'b0;
    end else if (cke_i) begin
      if (fifo_if.w_en_i & w_full_q) w_ovf_q <= 1'b1;
      if (fifo_if.r_en_i & r_empty_q) r_unf_q <= 1'b1;
    end
  end

  assign w_overflow_o  = w_ovf_q;
  assign r_underflow_o = r_unf_q;
`else
  // error flags compiled out
`endif

endmodule

// File: tb/tb_iob_fifo_sync_asym.sv
// Directed bench for iob_fifo_sync_asym: 8/8, 32->8 and 8->32 instances
// each backed by a behavioural bank RAM with registered read.
module tb_iob_fifo_sync_asym;

  logic clk = 1'b0;
  logic rst;
  logic cke;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  iob_fifo_sync_asym_if #(.W_DATA_W(8),  .R_DATA_W(8),  .ADDR_W(4)) i0 ();
  iob_fifo_sync_asym_if #(.W_DATA_W(32), .R_DATA_W(8),  .ADDR_W(4)) i1 ();
  iob_fifo_sync_asym_if #(.W_DATA_W(8),  .R_DATA_W(32), .ADDR_W(4)) i2 ();

  // instance 0 memory: one bank of 16 bytes
  logic       mclk0;
  logic [0:0] we0, re0;
  logic [3:0] wa0, ra0;
  logic [7:0] wd0, rd0;
  logic [7:0] m0 [16];
  always @(posedge mclk0) begin
    if (we0[0]) m0[wa0] <= wd0;
    if (re0[0]) rd0 <= m0[ra0];
  end

  // instances 1/2 memory: four banks of 4 bytes
  logic        mclk1, mclk2;
  logic [3:0]  we1, re1, we2, re2;
  logic [1:0]  wa1, ra1, wa2, ra2;
  logic [31:0] wd1, rd1, wd2, rd2;
  logic [7:0]  m1 [4][4];
  logic [7:0]  m2 [4][4];
  always @(posedge mclk1) begin
    for (int p = 0; p < 4; p++) begin
      if (we1[p]) m1[p][wa1] <= wd1[p*8 +: 8];
      if (re1[p]) rd1[p*8 +: 8] <= m1[p][ra1];
    end
  end
  always @(posedge mclk2) begin
    for (int p = 0; p < 4; p++) begin
      if (we2[p]) m2[p][wa2] <= wd2[p*8 +: 8];
      if (re2[p]) rd2[p*8 +: 8] <= m2[p][ra2];
    end
  end

  iob_fifo_sync_asym #(.W_DATA_W(8), .R_DATA_W(8), .ADDR_W(4)) u0 (
    .clk_i(clk), .rst_i(rst), .cke_i(cke), .fifo_if(i0.slave),
    .ext_mem_clk_o(mclk0), .ext_mem_w_en_o(we0),
    .ext_mem_w_addr_o(wa0), .ext_mem_w_data_o(wd0),
    .ext_mem_r_en_o(re0), .ext_mem_r_addr_o(ra0),
    .ext_mem_r_data_i(rd0)
  );

  iob_fifo_sync_asym #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4)) u1 (
    .clk_i(clk), .rst_i(rst), .cke_i(cke), .fifo_if(i1.slave),
    .ext_mem_clk_o(mclk1), .ext_mem_w_en_o(we1),
    .ext_mem_w_addr_o(wa1), .ext_mem_w_data_o(wd1),
    .ext_mem_r_en_o(re1), .ext_mem_r_addr_o(ra1),
    .ext_mem_r_data_i(rd1)
  );

  iob_fifo_sync_asym #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) u2 (
    .clk_i(clk), .rst_i(rst), .cke_i(cke), .fifo_if(i2.slave),
    .ext_mem_clk_o(mclk2), .ext_mem_w_en_o(we2),
    .ext_mem_w_addr_o(wa2), .ext_mem_w_data_o(wd2),
    .ext_mem_r_en_o(re2), .ext_mem_r_addr_o(ra2),
    .ext_mem_r_data_i(rd2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int   wcnt, rcnt, cyc;
  logic wa, ra;

  initial begin
    rst = 1'b1;
    cke = 1'b1;
    i0.w_en_i = 0; i0.w_data_i = '0; i0.r_en_i = 0;
    i1.w_en_i = 0; i1.w_data_i = '0; i1.r_en_i = 0;
    i2.w_en_i = 0; i2.w_data_i = '0; i2.r_en_i = 0;
    step();
    step();
    rst = 1'b0;

    chk("rst_level", i0.level_o, 0);
    chk("rst_empty", i0.r_empty_o, 1);
    chk("rst_full", i0.w_full_o, 0);
    chk("rst_rdata", i0.r_data_o, 0);
    chk("rst_u1_empty", i1.r_empty_o, 1);
    chk("rst_u2_empty", i2.r_empty_o, 1);

    // fill 8/8 FIFO with 0..15
    for (int i = 0; i < 16; i++) begin
      i0.w_en_i = 1; i0.w_data_i = 8'(i);
      step();
    end
    i0.w_en_i = 0;
    chk("fill_level", i0.level_o, 16);
    chk("fill_full", i0.w_full_o, 1);
    chk("fill_empty", i0.r_empty_o, 0);

    // write while full is ignored
    i0.w_en_i = 1; i0.w_data_i = 8'hAA;
    step();
    i0.w_en_i = 0;
    chk("ovf_level", i0.level_o, 16);
    chk("ovf_full", i0.w_full_o, 1);

    // cke low freezes state
    cke = 0; i0.r_en_i = 1;
    step();
    cke = 1; i0.r_en_i = 0;
    chk("cke_level", i0.level_o, 16);

    // drain in order
    for (int i = 0; i < 16; i++) begin
      i0.r_en_i = 1;
      step();
      chk("drain_data", i0.r_data_o, 32'(i));
    end
    i0.r_en_i = 0;
    chk("drain_empty", i0.r_empty_o, 1);
    chk("drain_level", i0.level_o, 0);
    chk("drain_full", i0.w_full_o, 0);

    // read while empty: data holds
    i0.r_en_i = 1;
    step();
    i0.r_en_i = 0;
    step();
    chk("unf_data", i0.r_data_o, 15);
    chk("unf_level", i0.level_o, 0);

    // 256-byte stream with throttled writes and reads
    wcnt = 0; rcnt = 0; cyc = 0;
    while (rcnt < 256 && cyc < 3000) begin
      wa = (wcnt < 256) && !i0.w_full_o && (cyc % 3 != 2);
      ra = !i0.r_empty_o && (cyc % 4 != 3);
      i0.w_en_i = wa; i0.w_data_i = 8'(wcnt); i0.r_en_i = ra;
      step();
      if (wa) wcnt++;
      if (ra) begin
        chk("stream_data", i0.r_data_o, 32'(rcnt % 256));
        rcnt++;
      end
      cyc++;
    end
    i0.w_en_i = 0; i0.r_en_i = 0;
    chk("stream_count", rcnt, 256);
    chk("stream_level", i0.level_o, 0);

    // simultaneous read/write at full
    for (int i = 0; i < 16; i++) begin
      i0.w_en_i = 1; i0.w_data_i = 8'(i);
      step();
    end
    i0.w_en_i = 1; i0.w_data_i = 8'h99; i0.r_en_i = 1;
    step();
    i0.w_en_i = 0; i0.r_en_i = 0;
    chk("rw_full_level", i0.level_o, 15);
    chk("rw_full_data", i0.r_data_o, 0);
    chk("rw_full_flag", i0.w_full_o, 0);
    for (int i = 1; i < 8; i++) begin
      i0.r_en_i = 1;
      step();
      chk("rw_mid_data", i0.r_data_o, 32'(i));
    end
    i0.r_en_i = 0;
    chk("rw_mid_level", i0.level_o, 8);
    i0.w_en_i = 1; i0.w_data_i = 8'h40; i0.r_en_i = 1;
    step();
    i0.w_en_i = 0; i0.r_en_i = 0;
    chk("rw_half_level", i0.level_o, 8);
    chk("rw_half_data", i0.r_data_o, 8);
    for (int i = 0; i < 8; i++) begin
      i0.r_en_i = 1;
      step();
      chk("rw_tail_data", i0.r_data_o, (i < 7) ? 32'(9 + i) : 32'h40);
    end
    i0.r_en_i = 0;
    chk("rw_tail_empty", i0.r_empty_o, 1);

    // 32-bit write, 8-bit read
    i1.w_en_i = 1; i1.w_data_i = 32'h03020100;
    step();
    i1.w_data_i = 32'h07060504;
    step();
    i1.w_en_i = 0;
    chk("u1_level", i1.level_o, 8);
    chk("u1_empty", i1.r_empty_o, 0);
    for (int i = 0; i < 8; i++) begin
      i1.r_en_i = 1;
      step();
      chk("u1_data", i1.r_data_o, 32'(i));
    end
    i1.r_en_i = 0;
    chk("u1_drain_empty", i1.r_empty_o, 1);
    chk("u1_drain_level", i1.level_o, 0);
    for (int k = 0; k < 4; k++) begin
      i1.w_en_i = 1; i1.w_data_i = 32'h11111111 * (k + 1);
      step();
      chk("u1_full", i1.w_full_o, (k == 3) ? 1 : 0);
    end
    i1.w_en_i = 0;
    chk("u1_full_level", i1.level_o, 16);

    // 8-bit write, 32-bit read
    for (int k = 0; k < 4; k++) begin
      i2.w_en_i = 1; i2.w_data_i = 8'(k);
      step();
      chk("u2_empty", i2.r_empty_o, (k < 3) ? 1 : 0);
    end
    i2.w_en_i = 0;
    i2.r_en_i = 1;
    step();
    i2.r_en_i = 0;
    chk("u2_data", i2.r_data_o, 32'h03020100);
    chk("u2_level", i2.level_o, 0);
    chk("u2_rd_empty", i2.r_empty_o, 1);

    // mid-stream reset
    for (int k = 4; k < 6; k++) begin
      i2.w_en_i = 1; i2.w_data_i = 8'(k);
      step();
    end
    i2.w_en_i = 0;
    chk("u2_pre_rst_level", i2.level_o, 2);
    rst = 1;
    step();
    rst = 0;
    chk("u2_rst_level", i2.level_o, 0);
    chk("u2_rst_empty", i2.r_empty_o, 1);
    chk("u2_rst_rdata", i2.r_data_o, 0);
    chk("u1_rst_level", i1.level_o, 0);
    chk("u1_rst_full", i1.w_full_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iob_fifo_sync_asym.md
Name: iob_fifo_sync_asym

Overview:
- Single-clock FIFO with independent write and read data widths; the wider width must be an integer multiple of the narrower.
- Storage is external: R parallel banks of MINDATA_W x 2^MINADDR_W two-port RAM with registered read, driven through ext_mem_* ports.
- Serves as the synchronous counterpart of the dual-clock FIFO in width-adaptation paths (byte stream <-> word stream) inside one clock domain.

Parameters:
- W_DATA_W, 8, write word width (bits).
- R_DATA_W, 8, read word width (bits).
- ADDR_W, 4, depth exponent counted in MINDATA_W units; capacity 2^ADDR_W narrow words.
- Derived (localparam):
  - MAXDATA_W = max(W_DATA_W, R_DATA_W); MINDATA_W = min of the two.
  - R = MAXDATA_W/MINDATA_W.
  - MINADDR_W = ADDR_W - clog2(R).
  - W_ADDR_W = (W_DATA_W==MAXDATA_W) ? MINADDR_W : ADDR_W.
  - R_ADDR_W = (R_DATA_W==MAXDATA_W) ? MINADDR_W : ADDR_W.

Ports:
- clk_i in 1 clock.
- rst_i in 1 synchronous active-high reset.
- cke_i in 1 clock enable; low freezes all state.
- w_en_i in 1 write request.
- w_data_i in W_DATA_W write data.
- w_full_o out 1 no room for one write word.
- r_en_i in 1 read request.
- r_data_o out R_DATA_W read data, registered.
- r_empty_o out 1 less than one read word stored.
- level_o out ADDR_W+1 occupancy in MINDATA_W units.
- ext_mem_clk_o out 1 = clk_i.
- ext_mem_w_en_o out R per-bank write enable.
- ext_mem_w_addr_o out MINADDR_W bank write address.
- ext_mem_w_data_o out MAXDATA_W bank write data; bank p uses bits [p*MINDATA_W +: MINDATA_W].
- ext_mem_r_en_o out R per-bank read enable.
- ext_mem_r_addr_o out MINADDR_W bank read address.
- ext_mem_r_data_i in MAXDATA_W bank read data, valid one cycle after r_en.

Behaviour:
- Reset (rst_i=1 at posedge): pointers=0, level_o=0, r_empty_o=1, w_full_o=0, r_data_o=0. Reset overrides everything; mid-operation reset discards contents.
- All state updates only at posedge clk_i with cke_i=1.
- Pointers: write pointer W_ADDR_W+1 bits, read pointer R_ADDR_W+1 bits, binary, natural wrap.
- Write accepted iff w_en_i & ~w_full_o & cke_i. Write while full: ignored, no state change.
- Read accepted iff r_en_i & ~r_empty_o & cke_i. Read while empty: ignored, r_data_o holds.
- Level arithmetic:
  - level_o += W_DATA_W/MINDATA_W per accepted write.
  - level_o -= R_DATA_W/MINDATA_W per accepted read.
  - Simultaneous accepted write and read apply both changes in the same cycle.
- Flags (registered, updated same edge as level_o):
  - w_full_o = level_o > 2^ADDR_W - W_DATA_W/MINDATA_W.
  - r_empty_o = level_o < R_DATA_W/MINDATA_W.
- Wide write (W>R): all ext_mem_w_en_o bits set; address = wptr[MINADDR_W-1:0].
- Narrow write (W<R): bank = wptr low clog2(R) bits; address = upper bits. Bank 0 holds the earliest narrow word (little-endian).
- Wide read (R>W): all banks enabled; r_data_o = ext_mem_r_data_i.
- Narrow read (R<W): only bank = rptr low clog2(R) bits is enabled; that bank select is registered to mux the output.
- Equal widths: R=1, a single bank.
- Read latency: r_data_o valid at the posedge following the one that accepted r_en_i, i.e. sampled 1 cycle after the request edge. r_data_o holds its value until the next accepted read.
- Ordering is byte-exact: bytes written in order are read in the same order regardless of width ratio.
- No bypass: a word written in cycle N is readable once r_empty_o deasserts, earliest at N+1.

Optional Feature:
- Macro IOB_FIFO_SYNC_ASYM_ERR_EN.
- When defined: adds outputs w_overflow_o and r_underflow_o (1 bit each).
  - w_overflow_o is sticky, set the cycle after a w_en_i attempt while w_full_o=1.
  - r_underflow_o is sticky, set the cycle after an r_en_i attempt while r_empty_o=1.
  - Both cleared only by rst_i.
- When undefined: ports absent, no logic.

Test Plan:
- W=R=8, ADDR_W=4: reset, write bytes 0..15 back-to-back -> w_full_o=1, level_o=16. A 17th write is ignored and level_o stays 16.
- Same config: read 16 times -> r_data_o=0..15 in order, then r_empty_o=1, level_o=0. A further r_en_i leaves r_data_o=15.
- Stream 256 bytes (values 0..255) with reads throttled by r_empty_o and writes by w_full_o -> every read matches its index; no loss or duplication across pointer wrap.
- At full (level 16): assert w_en_i and r_en_i together -> read accepted, write rejected, level_o=15. At level 8, both together -> level_o stays 8 and data order is preserved.
- W=32, R=8, ADDR_W=4: write 0x03020100 and 0x07060504 -> level_o=8, reads give 0..7. Four writes give w_full_o=1.
- W=8, R=32: write bytes 0..3 -> r_empty_o goes 1->0 only after the 4th byte, read gives 0x03020100. Assert rst_i mid-stream -> level_o=0, r_empty_o=1 next cycle.
